// File: rtl/alarm_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : alarm_time_keeper
// Brief    : BCD HH:MM:SS clock with set-time / set-alarm modes and buttons.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_time_keeper #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic        s2clk,
  input  logic        reset,
  input  logic        set_time,
  input  logic        set_alarm,
  input  logic        push_hr,
  input  logic        push_min,
  output logic [15:0] current,
  output logic [15:0] alarm,
  output logic [7:0]  sec,
  output logic [1:0]  mode
);

  localparam logic [1:0] c_ST_RUN       = 2'b00;
  localparam logic [1:0] c_ST_SET_TIME  = 2'b01;
  localparam logic [1:0] c_ST_SET_ALARM = 2'b10;

  localparam int               c_PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PW-1:0]  c_PS_TOP = c_PW'(TICKS_PER_SEC - 1);
  localparam logic [c_PW-1:0]  c_PS_ONE = c_PW'(1);

  // BCD 00..59 increment with wrap, no carry out
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [1:0]      r_mode;
  logic [c_PW-1:0] r_presc;
  logic [7:0]      r_sec;
  logic [15:0]     r_cur;
  logic [15:0]     r_alm;
  logic            r_hr_s, r_hr_p, r_min_s, r_min_p;

  logic [1:0]      w_mode_nxt;
  logic [c_PW-1:0] w_presc_nxt;
  logic [7:0]      w_sec_nxt;
  logic [15:0]     w_cur_nxt;
  logic [15:0]     w_alm_nxt;
  logic            w_tick, w_hr_edge, w_min_edge;

  assign w_hr_edge  = r_hr_s  & ~r_hr_p;
  assign w_min_edge = r_min_s & ~r_min_p;
  assign w_tick     = (r_mode != c_ST_SET_TIME) && (r_presc == c_PS_TOP);

  always_comb begin
    if (set_time)       w_mode_nxt = c_ST_SET_TIME;
    else if (set_alarm) w_mode_nxt = c_ST_SET_ALARM;
    else                w_mode_nxt = c_ST_RUN;
  end

  always_comb begin
    w_presc_nxt = r_presc;
    w_sec_nxt   = r_sec;
    w_cur_nxt   = r_cur;
    w_alm_nxt   = r_alm;
    if (r_mode == c_ST_SET_TIME) begin
      w_presc_nxt = '0;
      w_sec_nxt   = 8'h00;
      if (w_min_edge) w_cur_nxt[7:0]  = bcd_inc60(r_cur[7:0]);
      if (w_hr_edge)  w_cur_nxt[15:8] = bcd_inc24(r_cur[15:8]);
    end else begin
      w_presc_nxt = w_tick ? '0 : r_presc + c_PS_ONE;
      if (w_tick) begin
        w_sec_nxt = bcd_inc60(r_sec);
        if (r_sec == 8'h59) begin
          w_cur_nxt[7:0] = bcd_inc60(r_cur[7:0]);
          if (r_cur[7:0] == 8'h59) w_cur_nxt[15:8] = bcd_inc24(r_cur[15:8]);
        end
      end
      // Alarm edits use a separate register, so they never collide with carries
      if (r_mode == c_ST_SET_ALARM) begin
        if (w_min_edge) w_alm_nxt[7:0]  = bcd_inc60(r_alm[7:0]);
        if (w_hr_edge)  w_alm_nxt[15:8] = bcd_inc24(r_alm[15:8]);
      end
    end
  end

  always_ff @(posedge s2clk or posedge reset) begin
    if (reset) begin
      r_mode  <= c_ST_RUN;
      r_presc <= '0;
      r_sec   <= 8'h00;
      r_cur   <= 16'h0000;
      r_alm   <= 16'h0700;
      r_hr_s  <= 1'b0;
      r_hr_p  <= 1'b0;
      r_min_s <= 1'b0;
      r_min_p <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_presc <= w_presc_nxt;
      r_sec   <= w_sec_nxt;
      r_cur   <= w_cur_nxt;
      r_alm   <= w_alm_nxt;
      r_hr_s  <= push_hr;
      r_hr_p  <= r_hr_s;
      r_min_s <= push_min;
      r_min_p <= r_min_s;
    end
  end

  assign current = r_cur;
  assign alarm   = r_alm;
  assign sec     = r_sec;
  assign mode    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_alarm_time_keeper.sv
`default_nettype none
// Testbench for alarm_time_keeper with TICKS_PER_SEC=2; expectations queued
// when stimulus is applied and popped when outputs are sampled.
module tb_alarm_time_keeper;

  logic        s2clk, reset, set_time, set_alarm, push_hr, push_min;
  logic [15:0] current, alarm;
  logic [7:0]  sec;
  logic [1:0]  mode;

  int          n_pass, n_total, n_edges;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  alarm_time_keeper #(.TICKS_PER_SEC(2)) dut (
    .s2clk(s2clk), .reset(reset), .set_time(set_time), .set_alarm(set_alarm),
    .push_hr(push_hr), .push_min(push_min), .current(current), .alarm(alarm),
    .sec(sec), .mode(mode)
  );

  initial begin
    s2clk = 1'b0;
    forever #5 s2clk = ~s2clk;
  end

  // Counts clock edges since reset release, the basis of the time model
  always @(posedge s2clk or posedge reset)
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge s2clk);
  endtask

  task automatic do_reset();
    set_time = 0; set_alarm = 0; push_hr = 0; push_min = 0;
    @(negedge s2clk); reset = 1;
    @(negedge s2clk); reset = 0;
  endtask

  task automatic pulse(input bit hr, input bit mn, input int n);
    repeat (n) begin
      push_hr = hr; push_min = mn; @(negedge s2clk);
      push_hr = 0;  push_min = 0;  @(negedge s2clk);
    end
    cyc(3);
  endtask

  task automatic test_reset();
    reset = 1; set_time = 0; set_alarm = 0; push_hr = 0; push_min = 0;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0700);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    cyc(2);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL reset_current: got %h expected %h", current, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (alarm !== e) $display("FAIL reset_alarm: got %h expected %h", alarm, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e) $display("FAIL reset_sec: got %h expected %h", sec, e[7:0]); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({14'h0, mode} !== e) $display("FAIL reset_mode: got %b expected %b", mode, e[1:0]); else n_pass++;
    reset = 0;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    cyc(1);
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e) $display("FAIL first_tick_early: got %h expected %h", sec, e[7:0]); else n_pass++;
    cyc(1);
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e) $display("FAIL first_tick: got %h expected %h", sec, e[7:0]); else n_pass++;
  endtask

  task automatic test_run();
    do_reset();
    cyc(120);
    exp_q.push_back({8'h00, to_bcd((n_edges / 2) % 60)});
    exp_q.push_back({8'h00, to_bcd(n_edges / 120)});
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e || e !== 16'h0000) $display("FAIL run_sec: got %h expected 00", sec); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (current !== e || e !== 16'h0001) $display("FAIL run_current: got %h expected 0001", current); else n_pass++;
  endtask

  task automatic test_set_time();
    do_reset();
    set_time = 1;
    exp_q.push_back(16'h0001);
    cyc(2);
    e = exp_q.pop_front(); n_total++;
    if ({14'h0, mode} !== e) $display("FAIL set_time_mode: got %b expected %b", mode, e[1:0]); else n_pass++;
    exp_q.push_back(16'h2359); exp_q.push_back(16'h0000);
    pulse(1, 0, 23); pulse(0, 1, 59);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL set_time_2359: got %h expected %h", current, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e) $display("FAIL set_time_sec_held: got %h expected %h", sec, e[7:0]); else n_pass++;
    exp_q.push_back(16'h2300);
    pulse(0, 1, 1);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL min_wrap_no_carry: got %h expected %h", current, e); else n_pass++;
    pulse(0, 1, 59);
    set_time = 0;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    cyc(121);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL day_wrap: got %h expected %h", current, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e) $display("FAIL day_wrap_sec: got %h expected %h", sec, e[7:0]); else n_pass++;
  endtask

  task automatic test_set_alarm();
    do_reset();
    set_alarm = 1;
    pulse(0, 1, 61);
    exp_q.push_back(16'h0701);
    exp_q.push_back({8'h00, to_bcd(n_edges / 120)});
    exp_q.push_back({8'h00, to_bcd((n_edges / 2) % 60)});
    exp_q.push_back(16'h0002);
    e = exp_q.pop_front(); n_total++;
    if (alarm !== e) $display("FAIL alarm_61_min: got %h expected %h", alarm, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (current !== e || e !== 16'h0001) $display("FAIL alarm_current_runs: got %h expected 0001", current); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e) $display("FAIL alarm_sec_runs: got %h expected %h", sec, e[7:0]); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({14'h0, mode} !== e) $display("FAIL alarm_mode: got %b expected %b", mode, e[1:0]); else n_pass++;
  endtask

  task automatic test_hold_and_both();
    do_reset();
    set_time = 1; cyc(2);
    push_min = 1; cyc(50); push_min = 0; cyc(3);
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL held_button: got %h expected %h", current, e); else n_pass++;
    exp_q.push_back(16'h0102);
    pulse(1, 1, 1);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL both_buttons: got %h expected %h", current, e); else n_pass++;
    exp_q.push_back(16'h2302); exp_q.push_back(16'h0002);
    pulse(1, 0, 22);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL hour_23: got %h expected %h", current, e); else n_pass++;
    pulse(1, 0, 1);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL hour_wrap: got %h expected %h", current, e); else n_pass++;
  endtask

  task automatic test_run_ignore();
    do_reset();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0700);
    pulse(1, 1, 1);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL run_ignore_current: got %h expected %h", current, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (alarm !== e) $display("FAIL run_ignore_alarm: got %h expected %h", alarm, e); else n_pass++;
    set_time = 1; set_alarm = 1;
    exp_q.push_back(16'h0001);
    cyc(1);
    e = exp_q.pop_front(); n_total++;
    if ({14'h0, mode} !== e) $display("FAIL mode_priority: got %b expected %b", mode, e[1:0]); else n_pass++;
    do_reset();
    push_min = 1; cyc(3); set_time = 1; cyc(4);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL held_across_mode: got %h expected %h", current, e); else n_pass++;
    push_min = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_alarm = 1; cyc(2);
    pulse(0, 1, 1);
    set_alarm = 0; set_time = 1; cyc(2);
    pulse(1, 0, 12); pulse(0, 1, 34);
    exp_q.push_back(16'h1234); exp_q.push_back(16'h0701);
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL mid_setup_current: got %h expected %h", current, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (alarm !== e) $display("FAIL mid_setup_alarm: got %h expected %h", alarm, e); else n_pass++;
    set_time = 0; cyc(5);
    #2 reset = 1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0700);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    #1;
    e = exp_q.pop_front(); n_total++;
    if (current !== e) $display("FAIL mid_reset_current: got %h expected %h", current, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (alarm !== e) $display("FAIL mid_reset_alarm: got %h expected %h", alarm, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({8'h00, sec} !== e) $display("FAIL mid_reset_sec: got %h expected %h", sec, e[7:0]); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if ({14'h0, mode} !== e) $display("FAIL mid_reset_mode: got %b expected %b", mode, e[1:0]); else n_pass++;
    @(negedge s2clk); reset = 0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_run();
    test_set_time();
    test_set_alarm();
    test_hold_and_both();
    test_run_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_time_keeper.md
ALARM_TIME_KEEPER -- requirements
Module: alarm_time_keeper

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 1000, giving the number of s2clk cycles per second.
REQ-002 The block SHALL have port s2clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port set_time, input, 1 bit: SPDT level; high requests time-set mode.
REQ-005 The block SHALL have port set_alarm, input, 1 bit: SPDT level; high requests alarm-set mode.
REQ-006 The block SHALL have port push_hr, input, 1 bit: synchronous button level; hour increment.
REQ-007 The block SHALL have port push_min, input, 1 bit: synchronous button level; minute increment.
REQ-008 The block SHALL have port current, output, 16 bits: BCD HH:MM, feeding the alarm-check current input.
REQ-009 The block SHALL have port alarm, output, 16 bits: BCD HH:MM alarm time, feeding the alarm-check alarm input.
REQ-010 The block SHALL have port sec, output, 8 bits: BCD seconds 00-59.
REQ-011 The block SHALL have port mode, output, 2 bits: 00 RUN, 01 SET_TIME, 10 SET_ALARM.

Function
REQ-012 BCD layout SHALL be [15:12] hour tens (0-2), [11:8] hour units, [7:4] minute tens (0-5), [3:0] minute units; no illegal BCD value shall ever appear on current, alarm or sec.
REQ-013 The FSM SHALL have states RUN, SET_TIME and SET_ALARM, registered each cycle from the inputs: set_time=1 gives SET_TIME (priority over set_alarm); set_time=0 with set_alarm=1 gives SET_ALARM; otherwise RUN.
REQ-014 mode SHALL reflect the registered FSM state, one cycle after the switch change.
REQ-015 Prescaler: a counter 0..TICKS_PER_SEC-1 SHALL increment every cycle in RUN and SET_ALARM, wrap to 0, and issue a one-cycle second tick on the wrap.
REQ-016 Each second tick SHALL advance sec; 59 wraps to 00 and carries one minute into current in the same cycle.
REQ-017 A minute carry SHALL take 59 to 00 with an hour carry; 23:59 SHALL wrap to 00:00.
REQ-018 In SET_TIME, the prescaler and sec SHALL be held at 0 and time SHALL not advance; counting resumes from sec=00 on leaving SET_TIME.
REQ-019 Button edge detect: each push input SHALL be registered, and a rising edge (current 1, previous 0) SHALL produce one increment; a held button gives exactly one increment.
REQ-020 In SET_TIME, a push_min edge SHALL increment the current minute field, 59 to 00 with no hour carry; a push_hr edge SHALL increment the current hour field, 23 to 00.
REQ-021 In SET_ALARM, the same edges SHALL modify alarm identically, while current keeps running per REQ-015..017.
REQ-022 In RUN, button edges SHALL be ignored.
REQ-023 Simultaneous push_hr and push_min edges SHALL both apply in the same cycle, with no carry interaction between them.
REQ-024 If a minute carry and a push_min edge coincide in SET_ALARM, they SHALL target different registers and both take effect.
REQ-025 Edge detect SHALL run in all modes, so a button held across a mode change does not cause an increment.
REQ-026 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 On reset assertion, the block SHALL immediately set current=16'h0000, alarm=16'h0700, sec=8'h00, mode=2'b00, prescaler=0 and edge registers=0, regardless of mid-operation state.
REQ-028 After reset deassertion, the first second tick SHALL occur TICKS_PER_SEC cycles later.

Verification (TICKS_PER_SEC=2)
REQ-029 Reset, then run 120 cycles in RUN -> sec=00 and current=16'h0001; after reset, alarm=16'h0700.
REQ-030 In SET_TIME, pulse push_hr 23 times and push_min 59 times -> current=16'h2359; return to RUN and run 120 cycles -> current=16'h0000, sec=00.
REQ-031 In SET_ALARM, pulse push_min 61 times -> alarm=16'h0701 (no hour carry); current keeps advancing meanwhile.
REQ-032 Hold push_min high 50 cycles in SET_TIME -> exactly one increment; pulse both buttons in the same cycle -> hour and minute each +1.
REQ-033 In RUN, pulse push_hr and push_min -> current and alarm unchanged; assert both set_time and set_alarm -> mode=01.
REQ-034 Assert reset mid-count at current=16'h1234 -> all outputs return to their REQ-027 values in the same cycle.
